// File: rtl/ysyx_bus_pkg.sv
// Shared encodings and default widths for the IFU/LSU memory bus arbiter.
package ysyx_bus_pkg;
  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

  // Bit positions inside the one-hot grant vector and the cooldown mask.
  localparam int GNT_IFU = 0;
  localparam int GNT_LSU = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IFU  = 2'd1,
    OWN_LSU  = 2'd2
  } owner_e;
endpackage

// File: rtl/ysyx_bus_arb_pick.sv
// Combinational winner select for the two bus masters; one-hot grant out.
// YSYX_ARB_RR_EN selects round-robin on contention, otherwise LSU has priority.
module ysyx_bus_arb_pick
  import ysyx_bus_pkg::*;
(
  input  logic       ifu_req_i,
  input  logic       lsu_req_i,
  input  logic [1:0] mask_i,
  input  owner_e     last_owner_i,
  output logic [1:0] gnt_o
);
  logic ifu_v, lsu_v, lsu_wins;

  assign ifu_v = ifu_req_i & ~mask_i[GNT_IFU];
  assign lsu_v = lsu_req_i & ~mask_i[GNT_LSU];

`ifdef YSYX_ARB_RR_EN
  // On contention the master that did not win last time goes first.
  assign lsu_wins = lsu_v & (~ifu_v | (last_owner_i != OWN_LSU));
`else
  logic unused_last_owner;
  assign unused_last_owner = ^last_owner_i;
  assign lsu_wins = lsu_v;
`endif

  assign gnt_o[GNT_LSU] = lsu_wins;
  assign gnt_o[GNT_IFU] = ifu_v & ~lsu_wins;
endmodule

// File: rtl/ysyx_bus_arbiter.sv
// Two-master (IFU read / LSU read-write) to one-slave memory bus arbiter.
// Optional macro YSYX_ARB_RR_EN enables round-robin arbitration.
module ysyx_bus_arbiter
  import ysyx_bus_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   ifu_araddr,
  input  logic                ifu_arvalid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_rvalid,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_req,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_rvalid,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rvalid,
  output logic                busy_o
);
  localparam int STRB_W = DATA_W / 8;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [1:0]          cool_q, cool_d;
  logic [1:0]          gnt;
  logic                resp_fire;
  owner_e              last_owner;

`ifdef YSYX_ARB_RR_EN
  owner_e last_q, last_d;
  assign last_owner = last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= OWN_IFU;
    else     last_q <= last_d;
  end
`else
  assign last_owner = OWN_IFU;
`endif

  ysyx_bus_arb_pick u_pick (
    .ifu_req_i    (ifu_arvalid),
    .lsu_req_i    (lsu_req),
    .mask_i       (cool_q),
    .last_owner_i (last_owner),
    .gnt_o        (gnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_NONE;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cool_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      cool_q  <= cool_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    cool_d  = '0;
`ifdef YSYX_ARB_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (gnt[GNT_LSU]) begin
          state_d = ST_REQ;
          owner_d = OWN_LSU;
          addr_d  = lsu_addr;
          wen_d   = lsu_wen;
          wdata_d = lsu_wdata;
          wstrb_d = lsu_wstrb;
`ifdef YSYX_ARB_RR_EN
          last_d  = OWN_LSU;
`endif
        end else if (gnt[GNT_IFU]) begin
          state_d = ST_REQ;
          owner_d = OWN_IFU;
          addr_d  = ifu_araddr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wstrb_d = '0;
`ifdef YSYX_ARB_RR_EN
          last_d  = OWN_IFU;
`endif
        end
      end
      ST_REQ: if (mem_ready) state_d = ST_RESP;
      ST_RESP: begin
        if (mem_rvalid) begin
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
          // The just-served master still holds its level request for a cycle.
          cool_d[GNT_IFU] = (owner_q == OWN_IFU);
          cool_d[GNT_LSU] = (owner_q == OWN_LSU);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign resp_fire  = (state_q == ST_RESP) & mem_rvalid;
  assign ifu_rvalid = resp_fire & (owner_q == OWN_IFU);
  assign lsu_rvalid = resp_fire & (owner_q == OWN_LSU);
  assign ifu_rdata  = ifu_rvalid ? mem_rdata : '0;
  assign lsu_rdata  = lsu_rvalid ? mem_rdata : '0;

  assign mem_valid  = (state_q == ST_REQ);
  assign mem_addr   = addr_q;
  assign mem_wen    = wen_q;
  assign mem_wdata  = wdata_q;
  assign mem_wstrb  = wstrb_q;
  assign busy_o     = (state_q != ST_IDLE);
endmodule

// File: doc/ysyx_bus_arbiter.md
Name: ysyx_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the single core memory bus.
- It sits between the instruction fetch unit (read-only master) and the load/store unit (read/write master), and drives one shared memory slave port.
- It grants one transaction at a time, latches the winner's request, and routes the slave response back to the granted master only.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
ifu_araddr  in  ADDR_W  IFU read address
ifu_arvalid  in  1  IFU read request (level)
ifu_rdata  out  DATA_W  IFU read data
ifu_rvalid  out  1  IFU response pulse
lsu_addr  in  ADDR_W  LSU address
lsu_req  in  1  LSU request (level)
lsu_wen  in  1  1 = write, 0 = read
lsu_wdata  in  DATA_W  LSU write data
lsu_wstrb  in  DATA_W/8  LSU byte strobes
lsu_rdata  out  DATA_W  LSU read data
lsu_rvalid  out  1  LSU response pulse (read data or write ack)
mem_valid  out  1  slave request valid
mem_ready  in  1  slave accepts request
mem_addr  out  ADDR_W  slave address
mem_wen  out  1  slave write enable
mem_wdata  out  DATA_W  slave write data
mem_wstrb  out  DATA_W/8  slave strobes
mem_rdata  in  DATA_W  slave read data
mem_rvalid  in  1  slave response pulse
busy_o  out  1  arbiter not in IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- FSM states: IDLE, REQ, RESP. Owner register values: NONE, IFU, LSU.
- IDLE:
  - If any request is present, latch the winner's addr/wen/wdata/wstrb and set owner, then go to REQ.
  - For IFU grants, latch wen=0 and wstrb=0.
- Arbitration in the default build: LSU has fixed priority over IFU when both request in the same cycle.
- REQ:
  - mem_valid=1; mem_* are driven from the latched registers.
  - The latched request is stable while mem_valid is high; it does not change if the master changes its inputs.
  - On mem_ready=1, go to RESP.
- RESP:
  - mem_valid=0.
  - On mem_rvalid=1, forward combinationally to the owner: <owner>_rvalid=1 and <owner>_rdata=mem_rdata in that same cycle.
  - The non-owner's rvalid stays 0.
  - Next state is IDLE; owner becomes NONE.
- Response outputs at all other times: rvalid outputs are 0; rdata outputs are 0 when not valid.
- Latency: request seen in cycle 0, mem_valid high in cycle 1. With a zero-wait slave (mem_ready in cycle 1, mem_rvalid in cycle 2), the master sees rvalid in cycle 2. At most one transaction is outstanding at any time.
- Master obligation: a master drops its request in the cycle after its rvalid. The arbiter ignores the just-served master's request for exactly one cycle after the response (IDLE cooldown), so a stale level request is never re-granted.
- If mem_rvalid arrives while in IDLE or REQ, it is ignored and no rvalid is produced.
- A master that deasserts its request while in REQ or RESP does not abort the transaction; it completes and the response is still pulsed.
- busy_o = (state != IDLE).
- Reset values: state=IDLE, owner=NONE, and every output is 0.
- Reset asserted mid-transaction: the transaction is dropped immediately and no rvalid is produced. The slave must be reset on the same rst.

Optional Feature:
- Macro YSYX_ARB_RR_EN.
- When defined: round-robin arbitration. A last_owner register (reset value IFU) is updated at each grant. On a simultaneous request, the master not recorded in last_owner wins.
- When undefined: fixed LSU priority, and the last_owner register is absent.
- Single-requester behaviour is identical in both builds.

Decomposition:
- Shared package ysyx_bus_pkg holds:
  - state encoding (IDLE/REQ/RESP)
  - owner encoding (NONE/IFU/LSU)
  - the default ADDR_W/DATA_W constants
- One sub-module is natural: ysyx_bus_arb_pick, a combinational winner select. Inputs are the two requests, the cooldown mask and last_owner; output is a one-hot grant.
- The FSM and latches stay in the top module.

Test Plan:
- IFU read only: ifu_araddr=0x80000000 with a zero-wait slave returning 0x00000413 -> mem_valid high in cycle 1 with mem_addr=0x80000000 and mem_wen=0; ifu_rvalid=1 with ifu_rdata=0x00000413 in cycle 2; lsu_rvalid stays 0.
- Simultaneous requests: IFU read at 0x80000004 and LSU write at 0x80001000 (wdata 0xDEADBEEF, wstrb 0xF) -> LSU is granted first with mem_wen=1; after lsu_rvalid, the IFU is granted after one cooldown cycle. With YSYX_ARB_RR_EN and last_owner=LSU, the IFU is granted first.
- Slave backpressure: mem_ready held low for 5 cycles while the master changes lsu_addr -> mem_addr stays at the latched value; a single lsu_rvalid is produced after mem_ready and mem_rvalid.
- Stale request: IFU keeps ifu_arvalid high for 3 cycles after ifu_rvalid -> no second mem_valid during the cooldown cycle. It is re-granted only if still high after the cooldown, which is a master violation and is flagged by the bench assertion.
- Reset in RESP: assert rst asynchronously while waiting for mem_rvalid -> mem_valid, busy_o and both rvalid outputs are 0 immediately; after rst is released, a new IFU request is serviced normally.
- Spurious response: mem_rvalid pulsed while in IDLE -> no rvalid on either master and the state is unchanged.
